// File: rtl/fec_msg_fifo_if.sv
// rtl/fec_msg_fifo_if.sv - handshake, data and status bundle for fec_msg_fifo
interface fec_msg_fifo_if #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 16
);
    localparam int LW = $clog2(ENTRIES + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, rd_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, rd_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fec_msg_fifo.sv
// rtl/fec_msg_fifo.sv - arbitrary-depth message FIFO with level, thresholds and sticky error flags
module fec_msg_fifo #(
    parameter int WIDTH     = 8,
    parameter int ENTRIES   = 16,
    parameter int AF_THRESH = ENTRIES - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input logic            clk,
    input logic            rst,
    fec_msg_fifo_if.slave  bus
);
    localparam int LW = $clog2(ENTRIES + 1);
    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    if (!(ENTRIES >= 2 && AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= ENTRIES)) begin : g_bad_params
        $error("fec_msg_fifo: illegal ENTRIES/AF_THRESH/AE_THRESH combination");
    end

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic             ovf_q;
    logic             unf_q;
    logic             is_full;
    logic             is_empty;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] dout;
    logic             valid;

    // Pointers wrap at ENTRIES-1, so depth need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status decodes straight from the occupancy register; pointers are never compared.
    always_comb begin
        is_full  = (cnt == LW'(ENTRIES));
        is_empty = (cnt == '0);
        wr_acc   = bus.wr_en && !is_full && !bus.flush;
        rd_acc   = bus.rd_en && !is_empty && !bus.flush;
    end

    // Storage array: no reset, only accepted writes land.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointer, occupancy and sticky error bookkeeping; rst and flush clear identically.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (bus.wr_en && is_full) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && is_empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally; zero when nothing is stored.
        always_comb begin
            valid = !is_empty;
            dout  = is_empty ? '0 : mem[rd_ptr];
        end
    end else begin : g_reg
        // Registered read: data lands one cycle after the accepted read and then holds.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout  <= '0;
                valid <= 1'b0;
            end else begin
                valid <= rd_acc;
                if (rd_acc) begin
                    dout <= mem[rd_ptr];
                end
            end
        end
    end

    assign bus.data_out     = dout;
    assign bus.rd_valid     = valid;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (cnt >= LW'(AF_THRESH));
    assign bus.almost_empty = (cnt <= LW'(AE_THRESH));
    assign bus.level        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
